// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the serial DAC transmit path: frame geometry,
// power-down mode codes, FSM state type and the frame-word builder.
package dac_spi_tx_pkg;

  localparam int DAC_FRAME_W = 16;
  localparam int DAC_DATA_W  = 12;

  // Power-down codes placed in frame[13:12]
  localparam logic [1:0] PD_NORMAL   = 2'b00;
  localparam logic [1:0] PD_1K_GND   = 2'b01;
  localparam logic [1:0] PD_100K_GND = 2'b10;
  localparam logic [1:0] PD_HIGH_Z   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Frame word as the DAC expects it: two don't-care zeros, mode, code
  function automatic logic [DAC_FRAME_W-1:0] buildFrame(
    input logic [1:0]            pd,
    input logic [DAC_DATA_W-1:0] code
  );
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/dac_spi_tx_sclk_tick_gen.sv
// SCLK phase timer: counts CLK_DIV clock cycles while enabled and emits a
// one-cycle tick on the last cycle of each SCLK half-period. Held at zero
// while disabled so every frame starts on a fresh phase boundary.
module dac_spi_tx_sclk_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             w_phaseEnd;

  assign w_phaseEnd = (r_cnt == CNT_W'(CLK_DIV - 1));
  assign o_tick     = i_enable && !i_restart && w_phaseEnd;

  // Half-period counter, cleared on restart, when idle or at each phase end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_enable || i_restart || w_phaseEnd) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC transmitter: accepts one 12-bit code per frame over a
// valid/ready handshake and shifts a 16-bit word out MSB first in SPI mode 2
// (SCLK idles high, DAC samples DIN on falling edges). Every output comes
// straight from a register.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int         CLK_DIV     = 2,
  parameter logic [1:0] PD_MODE     = PD_NORMAL,
  parameter int         CS_HIGH_MIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DAC_DATA_W-1:0]  sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  output logic                   dac_sclk,
  output logic                   dac_cs_n,
  output logic                   dac_din,
  output logic                   busy,
  output logic                   frame_done,
  output logic [DAC_FRAME_W-1:0] frame_count
);

  localparam int GAP_W = (CS_HIGH_MIN > 1) ? $clog2(CS_HIGH_MIN) : 1;

  state_t                 r_state, w_stateNext;
  logic [14:0]            r_shiftReg, w_shiftRegNext;
  logic [3:0]             r_bitCnt, w_bitCntNext;
  logic [GAP_W-1:0]       r_gapCnt, w_gapCntNext;
  logic                   r_ready, w_readyNext;
  logic                   r_sclk, w_sclkNext;
  logic                   r_csN, w_csNNext;
  logic                   r_din, w_dinNext;
  logic                   r_busy, w_busyNext;
  logic                   r_done, w_doneNext;
  logic [DAC_FRAME_W-1:0] r_count, w_countNext;

  logic                   w_accept;
  logic                   w_shiftActive;
  logic                   w_tick;
  logic [DAC_FRAME_W-1:0] w_frame;

  assign w_accept      = (r_state == ST_IDLE) && r_ready && sample_valid;
  assign w_shiftActive = (r_state == ST_SHIFT);
  assign w_frame       = buildFrame(PD_MODE, sample_in);

  dac_spi_tx_sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_enable (w_shiftActive),
    .i_restart(w_accept),
    .o_tick   (w_tick)
  );

  // Next-state and next-output logic; everything holds unless a rule fires
  always_comb begin
    w_stateNext    = r_state;
    w_shiftRegNext = r_shiftReg;
    w_bitCntNext   = r_bitCnt;
    w_gapCntNext   = r_gapCnt;
    w_readyNext    = r_ready;
    w_sclkNext     = r_sclk;
    w_csNNext      = r_csN;
    w_dinNext      = r_din;
    w_busyNext     = r_busy;
    w_doneNext     = 1'b0;
    w_countNext    = r_count;

    case (r_state)
      ST_IDLE: begin
        w_readyNext = 1'b1;
        if (w_accept) begin
          w_shiftRegNext = w_frame[14:0];
          w_dinNext      = w_frame[15];
          w_bitCntNext   = 4'd0;
          w_readyNext    = 1'b0;
          w_busyNext     = 1'b1;
          w_csNNext      = 1'b0;
          w_stateNext    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_tick) begin
          if (r_sclk) begin
            w_sclkNext = 1'b0;
          end else begin
            w_sclkNext = 1'b1;
            if (r_bitCnt != 4'd15) begin
              w_dinNext      = r_shiftReg[14];
              w_shiftRegNext = {r_shiftReg[13:0], 1'b0};
              w_bitCntNext   = r_bitCnt + 4'd1;
            end else begin
              w_csNNext    = 1'b1;
              w_dinNext    = 1'b0;
              w_busyNext   = 1'b0;
              w_doneNext   = 1'b1;
              w_countNext  = r_count + 16'd1;
              w_gapCntNext = '0;
              w_stateNext  = ST_GAP;
            end
          end
        end
      end

      ST_GAP: begin
        if (r_gapCnt == GAP_W'(CS_HIGH_MIN - 1)) begin
          w_readyNext = 1'b1;
          w_stateNext = ST_IDLE;
        end else begin
          w_gapCntNext = r_gapCnt + GAP_W'(1);
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame and parks the bus idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shiftReg <= '0;
      r_bitCnt   <= '0;
      r_gapCnt   <= '0;
      r_ready    <= 1'b0;
      r_sclk     <= 1'b1;
      r_csN      <= 1'b1;
      r_din      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_shiftReg <= w_shiftRegNext;
      r_bitCnt   <= w_bitCntNext;
      r_gapCnt   <= w_gapCntNext;
      r_ready    <= w_readyNext;
      r_sclk     <= w_sclkNext;
      r_csN      <= w_csNNext;
      r_din      <= w_dinNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_count    <= w_countNext;
    end
  end

  assign sample_ready = r_ready;
  assign dac_sclk     = r_sclk;
  assign dac_cs_n     = r_csN;
  assign dac_din      = r_din;
  assign busy         = r_busy;
  assign frame_done   = r_done;
  assign frame_count  = r_count;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=2/normal mode/gap 4 and
// CLK_DIV=1/high-Z mode/gap 1) checked every cycle against a timeline model
// that derives all outputs from the number of cycles since the last accept,
// plus a DAC-side receiver that shifts DIN in on SCLK falling edges.
module tb_dac_spi_tx;

  logic        clk;
  logic        rst;
  logic        validIn[2];
  logic [11:0] sampleIn[2];
  logic        readyO[2];
  logic        sclkO[2];
  logic        csO[2];
  logic        dinO[2];
  logic        busyO[2];
  logic        doneO[2];
  logic [15:0] countO[2];

  int total;
  int bad;
  int cyc;

  // Timeline model: -2 = in/just out of reset, -1 = idle and ready,
  // >= 0 = cycles elapsed since the accepting clock edge
  int          ph[2];
  logic [15:0] frameM[2];
  logic [15:0] countM[2];
  int          lastAcc[2];
  int          spacing[2];

  // DAC-side receiver state
  logic        prevSclk[2];
  logic        prevCs[2];
  logic [15:0] capW[2];
  int          fallCnt[2];
  int          lowCnt[2];
  int          lastLow[2];
  int          framesSeen[2];
  int          doneSeen[2];
  logic [15:0] seen0[$];
  logic [15:0] seen1[$];

  dac_spi_tx #(
    .CLK_DIV    (2),
    .PD_MODE    (2'b00),
    .CS_HIGH_MIN(4)
  ) u0 (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sampleIn[0]),
    .sample_valid(validIn[0]),
    .sample_ready(readyO[0]),
    .dac_sclk    (sclkO[0]),
    .dac_cs_n    (csO[0]),
    .dac_din     (dinO[0]),
    .busy        (busyO[0]),
    .frame_done  (doneO[0]),
    .frame_count (countO[0])
  );

  dac_spi_tx #(
    .CLK_DIV    (1),
    .PD_MODE    (2'b11),
    .CS_HIGH_MIN(1)
  ) u1 (
    .clk         (clk),
    .rst         (rst),
    .sample_in   (sampleIn[1]),
    .sample_valid(validIn[1]),
    .sample_ready(readyO[1]),
    .dac_sclk    (sclkO[1]),
    .dac_cs_n    (csO[1]),
    .dac_din     (dinO[1]),
    .busy        (busyO[1]),
    .frame_done  (doneO[1]),
    .frame_count (countO[1])
  );

  function automatic int divOf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gapOf(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic logic [1:0] pdOf(input int i);
    return (i == 0) ? 2'b00 : 2'b11;
  endfunction

  // k-th word the DAC receiver has captured (sentinel if none yet)
  function automatic logic [31:0] seenIdx(input int i, input int k);
    if (i == 0) return (k < seen0.size()) ? {16'h0, seen0[k]} : 32'hDEAD_BEEF;
    return (k < seen1.size()) ? {16'h0, seen1[k]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lastSeen(input int i);
    if (i == 0) return (seen0.size() > 0) ? {16'h0, seen0[seen0.size()-1]} : 32'hDEAD_BEEF;
    return (seen1.size() > 0) ? {16'h0, seen1[seen1.size()-1]} : 32'hDEAD_BEEF;
  endfunction

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s (u%0d) at cycle %0d: got 0x%0h, expected 0x%0h",
               name, inst, cyc, act, exp);
    end
  endtask

  // Offer one code and hold valid until the instance takes it
  task automatic applyStimulus(input int i, input logic [11:0] code, input bit keepValid);
    bit acc;
    acc = 0;
    validIn[i]  = 1'b1;
    sampleIn[i] = code;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = readyO[i];
      @(posedge clk);
      #2;
    end
    if (!keepValid) validIn[i] = 1'b0;
    if (!acc) checkOutput("accept_timeout", i, 32'd0, 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Per-cycle compare against the timeline model, DAC receiver, model advance
  always @(negedge clk) begin
    int d, g, j, p;
    logic eCs, eSclk, eDin, eRdy, eBusy, eDone;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ph[i]      = -2;
        countM[i]  = '0;
        lastAcc[i] = -1;
      end
      d = divOf(i);
      g = gapOf(i);
      j = ph[i];
      eCs = 1'b1; eSclk = 1'b1; eDin = 1'b0; eRdy = 1'b0; eBusy = 1'b0; eDone = 1'b0;
      if (j == -1) begin
        eRdy = 1'b1;
      end else if (j >= 0 && j < 32 * d) begin
        p     = j / d;
        eCs   = 1'b0;
        eSclk = ((p % 2) == 0);
        eDin  = frameM[i][15 - p / 2];
        eBusy = 1'b1;
      end else if (j == 32 * d) begin
        eDone = 1'b1;
      end
      checkOutput("dac_cs_n", i, csO[i], eCs);
      checkOutput("dac_sclk", i, sclkO[i], eSclk);
      checkOutput("dac_din", i, dinO[i], eDin);
      checkOutput("sample_ready", i, readyO[i], eRdy);
      checkOutput("busy", i, busyO[i], eBusy);
      checkOutput("frame_done", i, doneO[i], eDone);
      checkOutput("frame_count", i, countO[i], countM[i]);

      if (rst) begin
        capW[i]    = '0;
        fallCnt[i] = 0;
        lowCnt[i]  = 0;
      end else begin
        if (doneO[i]) doneSeen[i]++;
        if (!csO[i]) begin
          lowCnt[i]++;
          if (prevSclk[i] && !sclkO[i]) begin
            capW[i] = {capW[i][14:0], dinO[i]};
            fallCnt[i]++;
          end
        end
        if (csO[i] && !prevCs[i]) begin
          checkOutput("dac_word", i, capW[i], frameM[i]);
          checkOutput("sclk_falls", i, fallCnt[i], 16);
          lastLow[i] = lowCnt[i];
          framesSeen[i]++;
          if (i == 0) seen0.push_back(capW[i]);
          else seen1.push_back(capW[i]);
          capW[i]    = '0;
          fallCnt[i] = 0;
          lowCnt[i]  = 0;
        end
      end
      prevSclk[i] = sclkO[i];
      prevCs[i]   = csO[i];

      if (rst) begin
        ph[i] = -2;
      end else if (ph[i] == -2) begin
        ph[i] = -1;
      end else if (ph[i] == -1) begin
        if (validIn[i]) begin
          ph[i]     = 0;
          frameM[i] = {2'b00, pdOf(i), sampleIn[i]};
          if (lastAcc[i] >= 0) spacing[i] = cyc - lastAcc[i];
          lastAcc[i] = cyc;
        end
      end else begin
        ph[i] = ph[i] + 1;
        if (ph[i] == 32 * d) countM[i] = countM[i] + 16'd1;
        if (ph[i] == 32 * d + g) ph[i] = -1;
      end
    end
  end

  // Directed scenarios followed by a randomized soak on both instances
  initial begin
    int n;
    int savedDone;
    int savedFrames;
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < 2; i++) begin
      validIn[i]    = 1'b0;
      sampleIn[i]   = '0;
      ph[i]         = -2;
      frameM[i]     = '0;
      countM[i]     = '0;
      lastAcc[i]    = -1;
      spacing[i]    = 0;
      prevSclk[i]   = 1'b1;
      prevCs[i]     = 1'b1;
      capW[i]       = '0;
      fallCnt[i]    = 0;
      lowCnt[i]     = 0;
      lastLow[i]    = 0;
      framesSeen[i] = 0;
      doneSeen[i]   = 0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(posedge clk);
    #1;
    checkOutput("ready_first_cycle", 0, readyO[0], 1);
    checkOutput("ready_first_cycle", 1, readyO[1], 1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("idle_cs_n", 0, csO[0], 1);
    checkOutput("idle_sclk", 0, sclkO[0], 1);
    checkOutput("idle_din", 0, dinO[0], 0);
    checkOutput("idle_busy", 0, busyO[0], 0);

    // Single frame
    @(posedge clk); #2;
    applyStimulus(0, 12'hA5C, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    checkOutput("single_word", 0, lastSeen(0), 32'h0A5C);
    checkOutput("single_cs_low_len", 0, lastLow[0], 64);
    checkOutput("single_done_pulses", 0, doneSeen[0], 1);
    checkOutput("single_frame_count", 0, countO[0], 1);

    // Back-to-back with valid held high
    @(posedge clk); #2;
    applyStimulus(0, 12'h000, 1'b1);
    applyStimulus(0, 12'hFFF, 1'b1);
    checkOutput("b2b_spacing_1", 0, spacing[0], 69);
    applyStimulus(0, 12'h800, 1'b0);
    checkOutput("b2b_spacing_2", 0, spacing[0], 69);
    repeat (80) @(posedge clk);
    #1;
    checkOutput("b2b_word_0", 0, seenIdx(0, 1), 32'h0000);
    checkOutput("b2b_word_1", 0, seenIdx(0, 2), 32'h0FFF);
    checkOutput("b2b_word_2", 0, seenIdx(0, 3), 32'h0800);
    checkOutput("b2b_frame_count", 0, countO[0], 4);

    // Input noise while a frame is shifting
    @(posedge clk); #2;
    applyStimulus(0, 12'h3C7, 1'b0);
    repeat (40) begin
      @(posedge clk); #2;
      sampleIn[0] = 12'($urandom);
      validIn[0]  = 1'($urandom_range(0, 1));
    end
    validIn[0] = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("noise_word", 0, seenIdx(0, 4), 32'h03C7);
    checkOutput("noise_frames", 0, framesSeen[0], 5);

    // Reset in the middle of a frame
    savedDone   = doneSeen[0];
    savedFrames = framesSeen[0];
    @(posedge clk); #2;
    applyStimulus(0, 12'hABC, 1'b0);
    n = 0;
    while (fallCnt[0] != 7 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("falls_before_reset", 0, fallCnt[0], 7);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_cs_n_async", 0, csO[0], 1);
    checkOutput("rst_sclk_async", 0, sclkO[0], 1);
    checkOutput("rst_din_async", 0, dinO[0], 0);
    checkOutput("rst_busy_async", 0, busyO[0], 0);
    checkOutput("rst_count_async", 0, countO[0], 0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_no_done", 0, doneSeen[0], savedDone);
    checkOutput("rst_no_frame", 0, framesSeen[0], savedFrames);
    @(posedge clk); #2;
    applyStimulus(0, 12'h123, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    checkOutput("after_rst_word", 0, lastSeen(0), 32'h0123);
    checkOutput("after_rst_count", 0, countO[0], 1);

    // Fast instance: CLK_DIV=1, high-Z power-down bits
    @(posedge clk); #2;
    applyStimulus(1, 12'h5A3, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("fast_word", 1, lastSeen(1), 32'h35A3);
    checkOutput("fast_cs_low_len", 1, lastLow[1], 32);
    checkOutput("fast_frame_count", 1, countO[1], 1);

    // Randomized soak on both instances
    repeat (2500) begin
      @(posedge clk); #2;
      for (int i = 0; i < 2; i++) begin
        validIn[i]  = ($urandom_range(0, 3) == 0);
        sampleIn[i] = 12'($urandom);
      end
    end
    validIn[0] = 1'b0;
    validIn[1] = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("soak_fast_frames", 1, (framesSeen[1] > 10), 1);
    checkOutput("soak_slow_frames", 0, (framesSeen[0] > 10), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
